// File: rtl/encoder8_pkg.sv
// Shared constants and index type for the 8-to-3 pending encoder.
// Used by: prio_enc8, encoder8_to_3_pending.
package encoder8_pkg;

  localparam int N_IN  = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [N_IN-1:0] onehot(idx_t i);
    logic [N_IN-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder.
// vec in; high_first selects MSB or LSB priority; idx/found out.
module prio_enc8
  import encoder8_pkg::*;
(
  input  logic [N_IN-1:0] vec,
  input  logic            high_first,
  output idx_t            idx,
  output logic            found
);

  // Last match in scan order wins, so scan
  // upward for MSB priority, downward for LSB.
  always_comb begin
    idx   = '0;
    found = |vec;
    if (high_first) begin
      for (int i = 0; i < N_IN; i++)
        if (vec[i]) idx = idx_t'(i);
    end else begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (vec[i]) idx = idx_t'(i);
    end
  end

endmodule

// File: rtl/encoder8_to_3_pending.sv
// Sticky-pending 8-to-3 request encoder with valid/ready output.
// clk/rst_n, en/req capture, out/out_valid/out_ready, pend/any_pend/dup.
module encoder8_to_3_pending
  import encoder8_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_IN-1:0] req,
  output idx_t            out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] pend,
  output logic            any_pend,
  output logic            dup
);

  idx_t            sel;
  logic            found;
  logic            take;
  logic            load;
  logic [N_IN-1:0] clr;
  logic [N_IN-1:0] cap;
  logic            dup_nx;

  prio_enc8 u_prio (
    .vec       (pend),
    .high_first(HIGH_FIRST),
    .idx       (sel),
    .found     (found)
  );

  assign take     = out_valid & out_ready;
  assign load     = (~out_valid | take) & found;
  assign clr      = load ? onehot(sel) : '0;
  assign cap      = en ? req : '0;
  assign any_pend = |pend;

  // A bit leaving pend this cycle and re-requested
  // is a fresh request, not a duplicate.
  assign dup_nx = (|(cap & pend & ~clr))
                | (out_valid & ~take & cap[out]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      dup       <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | cap;
      dup  <= dup_nx;
      if (load) begin
        out       <= sel;
        out_valid <= 1'b1;
      end else if (take) begin
        out       <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
